input_manager: RTL and testbench

Runtime UART input path for the multicycle CPU. It is the receive-side counterpart of output_manager and supplies data to the READI/READF (word) and byte-read instructions. It deserialises 8-bit UART frames on UART_RX into a byte FIFO. On CPU request it pops 1 or 4 bytes, assembles them big-endian, and returns the result with a one-cycle valid pulse; the CPU stalls in MODE_EX until then.

---
 rtl/cpu_io_pkg.sv | 29 ++
 rtl/uart_rx_byte.sv | 161 ++++++++++++++++
 rtl/input_manager.sv | 168 ++++++++++++++++
 tb/tb_input_manager.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_io_pkg.sv
// Shared definitions for the CPU runtime UART I/O blocks (input_manager and
// output_manager). Optional macro UART_PARITY_EN adds the R_PARITY state
// used by 8E1 framing.
package cpu_io_pkg;

  // Default baud divider: 100 MHz system clock, 115200 baud.
  localparam int CLK_PER_BIT_115200 = 868;

  // Bytes assembled for a READI/READF word.
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP
`ifdef UART_PARITY_EN
    ,
    R_PARITY
`endif
  } rx_state_t;

  typedef enum logic [1:0] {
    A_IDLE,
    A_COLLECT,
    A_DONE
  } asm_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// UART byte receiver: 2-flop synchroniser, start/data/stop FSM, bit timing.
// Emits a one-cycle byte_valid_o pulse per good frame; byte_data_o stays
// stable until the next frame starts shifting in.
// Optional macro UART_PARITY_EN: 8E1 framing with an even-parity check.
module uart_rx_byte
  import cpu_io_pkg::*;
#(
  parameter int CLK_PER_BIT = CLK_PER_BIT_115200
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  input  logic       enable_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       frame_err_pulse_o
`ifdef UART_PARITY_EN
  ,
  output logic       parity_err_pulse_o
`endif
);

  localparam int CW = $clog2(CLK_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_valid_q, byte_valid_d;
  logic            frame_err_q, frame_err_d;
`ifdef UART_PARITY_EN
  logic            par_bad_q, par_bad_d;
  logic            parity_err_q, parity_err_d;
`endif

  // Synchronise the asynchronous line; reset to idle-high so no false start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Receiver next-state, bit timing and result pulses.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
`ifdef UART_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      R_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        // ENABLE only gates new frames; a running frame always completes.
        if (enable_i && rx_prev_q && !rx_sync_q) state_d = R_START;
      end
      R_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          state_d = rx_sync_q ? R_IDLE : R_DATA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      R_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = R_PARITY;
`else
            state_d = R_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
`ifdef UART_PARITY_EN
      R_PARITY: begin
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          par_bad_d = rx_sync_q ^ (^shift_q);
          state_d   = R_STOP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
`endif
      R_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = R_IDLE;
          if (!rx_sync_q) frame_err_d = 1'b1;
`ifdef UART_PARITY_EN
          else if (par_bad_q) parity_err_d = 1'b1;
`endif
          else byte_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  // Control state of the receiver.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= R_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
`ifdef UART_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Data shift register; only qualified by byte_valid, so no reset needed.
  always_ff @(posedge clk_i) begin
    shift_q <= shift_d;
  end

  assign byte_valid_o      = byte_valid_q;
  assign byte_data_o       = shift_q;
  assign frame_err_pulse_o = frame_err_q;
`ifdef UART_PARITY_EN
  assign parity_err_pulse_o = parity_err_q;
`endif

endmodule

// File: rtl/input_manager.sv
// Runtime UART input path for the multicycle CPU: receiver -> byte FIFO ->
// big-endian word/byte assembler with a one-cycle rd_valid pulse.
// Optional macro UART_PARITY_EN: 8E1 frames and a sticky parity_err output.
module input_manager
  import cpu_io_pkg::*;
#(
  parameter int CLK_PER_BIT = CLK_PER_BIT_115200,
  parameter int FIFO_DEPTH  = 512,
  parameter int FIFO_AW     = $clog2(FIFO_DEPTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             UART_RX,
  input  logic             ENABLE,
  input  logic             rd_req,
  input  logic             rd_word,
  output logic             rd_valid,
  output logic [31:0]      rd_data,
  output logic [FIFO_AW:0] fifo_count,
  output logic             overrun,
  output logic             frame_err
`ifdef UART_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err_pulse;
`ifdef UART_PARITY_EN
  logic       parity_err_pulse;
  logic       parity_err_q;
`endif

  uart_rx_byte #(
    .CLK_PER_BIT(CLK_PER_BIT)
  ) u_rx (
    .clk_i             (CLK),
    .rst_ni            (RST_N),
    .rx_i              (UART_RX),
    .enable_i          (ENABLE),
    .byte_valid_o      (byte_valid),
    .byte_data_o       (byte_data),
    .frame_err_pulse_o (frame_err_pulse)
`ifdef UART_PARITY_EN
    ,
    .parity_err_pulse_o(parity_err_pulse)
`endif
  );

  // FIFO storage and pointers
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               full, empty, push, pop;
  logic [7:0]         head;
  logic               overrun_q, frame_err_q;

  // Assembler state
  asm_state_t  asm_q, asm_d;
  logic [2:0]  need_q, need_d;
  logic [31:0] shreg_q, shreg_d;
  logic        rd_valid_q, rd_valid_d;
  logic [31:0] rd_data_q, rd_data_d;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);
  assign push  = byte_valid && !full;
  assign pop   = (asm_q == A_COLLECT) && !empty;
  assign head  = mem_q[rd_ptr_q];

  // Occupancy bookkeeping; simultaneous push and pop leave the count as is.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Assembler: latch request size, pop bytes MSB-first, then pulse valid.
  always_comb begin
    asm_d      = asm_q;
    need_d     = need_q;
    shreg_d    = shreg_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    case (asm_q)
      A_IDLE: begin
        if (rd_req) begin
          need_d  = rd_word ? 3'(BYTES_PER_WORD) : 3'd1;
          shreg_d = '0;
          asm_d   = A_COLLECT;
        end
      end
      A_COLLECT: begin
        if (pop) begin
          shreg_d = {shreg_q[23:0], head};
          need_d  = need_q - 3'd1;
          if (need_q == 3'd1) asm_d = A_DONE;
        end
      end
      A_DONE: begin
        rd_valid_d = 1'b1;
        rd_data_d  = shreg_q;
        asm_d      = A_IDLE;
      end
      default: asm_d = A_IDLE;
    endcase
  end

  // Control registers: pointers, count, sticky flags, assembler, outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      asm_q       <= A_IDLE;
      need_q      <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q     <= count_d;
      overrun_q   <= overrun_q | (byte_valid & full);
      frame_err_q <= frame_err_q | frame_err_pulse;
      asm_q       <= asm_d;
      need_q      <= need_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

`ifdef UART_PARITY_EN
  // Sticky parity error, cleared only by reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) parity_err_q <= 1'b0;
    else        parity_err_q <= parity_err_q | parity_err_pulse;
  end
  assign parity_err = parity_err_q;
`endif

  // Byte storage; contents are only meaningful between the pointers.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= byte_data;
  end

  // Word shift register; cleared on every accepted request.
  always_ff @(posedge CLK) begin
    shreg_q <= shreg_d;
  end

  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign fifo_count = count_q;
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_input_manager.sv
// Testbench for input_manager: table of frame/read vectors plus hand
// sequences for reset mid-frame, request-before-data, parity and overrun.
// Honours UART_PARITY_EN for the optional parity port and frames.
module tb_input_manager;

  localparam int CPB   = 16;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx;
  logic          en;
  logic          rd_req;
  logic          rd_word;
  logic          rd_valid;
  logic [31:0]   rd_data;
  logic [AW:0]   fifo_count;
  logic          overrun;
  logic          frame_err;
`ifdef UART_PARITY_EN
  logic          parity_err;
  logic          par_flip = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;
  int vld_cnt = 0;
  logic [31:0] vld_data = '0;

  input_manager #(
    .CLK_PER_BIT(CPB),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .UART_RX   (rx),
    .ENABLE    (en),
    .rd_req    (rd_req),
    .rd_word   (rd_word),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .fifo_count(fifo_count),
    .overrun   (overrun),
    .frame_err (frame_err)
`ifdef UART_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rd_valid) begin
      vld_cnt  <= vld_cnt + 1;
      vld_data <= rd_data;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          is_rd;
    logic [7:0]  data;
    logic        en;
    logic        stop;
    logic        word;
    logic [31:0] exp_data;
    int          exp_cnt;
    logic        exp_ferr;
    int          exp_lat;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge after the frame and one idle bit.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_PARITY_EN
    rx = (^d) ^ par_flip;
    repeat (CPB) @(negedge clk);
`endif
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  // Issue one request at a negedge; lat counts edges after the accept edge.
  task automatic do_read(input logic w, output logic [31:0] data, output int lat, output bit ok);
    rd_req  = 1'b1;
    rd_word = w;
    @(negedge clk);
    rd_req = 1'b0;
    lat = 0;
    ok  = 1'b0;
    while (!ok && lat < 64) begin
      @(negedge clk);
      lat++;
      if (rd_valid) ok = 1'b1;
    end
    data = rd_data;
    @(negedge clk);
    chk("valid_one_cycle", 32'(rd_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  b41;
    int          lat;
    bit          ok;
    int          base;

    //               rd  data   en stop word exp_data       cnt ferr lat
    tbl[0]  = '{1'b0, 8'h3F, 1'b1, 1'b1, 1'b0, 32'h0,        1, 1'b0, 0};
    tbl[1]  = '{1'b0, 8'h80, 1'b1, 1'b1, 1'b0, 32'h0,        2, 1'b0, 0};
    tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0,        3, 1'b0, 0};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0,        4, 1'b0, 0};
    tbl[4]  = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 32'h3F800000, 0, 1'b0, 5};
    tbl[5]  = '{1'b0, 8'h55, 1'b1, 1'b0, 1'b0, 32'h0,        0, 1'b1, 0};
    tbl[6]  = '{1'b0, 8'h10, 1'b1, 1'b1, 1'b0, 32'h0,        1, 1'b1, 0};
    tbl[7]  = '{1'b0, 8'h99, 1'b0, 1'b1, 1'b0, 32'h0,        1, 1'b1, 0};
    tbl[8]  = '{1'b0, 8'h11, 1'b1, 1'b1, 1'b0, 32'h0,        2, 1'b1, 0};
    tbl[9]  = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 32'h00000010, 1, 1'b1, 2};
    tbl[10] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 32'h00000011, 0, 1'b1, 2};

    rx      = 1'b1;
    en      = 1'b1;
    rd_req  = 1'b0;
    rd_word = 1'b0;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    chk("reset_rd_data", rd_data, 32'd0);
    chk("reset_count", 32'(fifo_count), 32'd0);
    chk("reset_overrun", 32'(overrun), 32'd0);
    chk("reset_frame_err", 32'(frame_err), 32'd0);
`ifdef UART_PARITY_EN
    chk("reset_parity_err", 32'(parity_err), 32'd0);
`endif
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Reset in the middle of 0x41, then a clean 0x42.
    b41 = 8'h41;
    rx  = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b41[i];
      repeat (CPB) @(negedge clk);
    end
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    send_frame(8'h42, 1'b1);
    chk("midreset_count", 32'(fifo_count), 32'd1);
    chk("midreset_frame_err", 32'(frame_err), 32'd0);
    chk("midreset_overrun", 32'(overrun), 32'd0);
    do_read(1'b0, d, lat, ok);
    chk("midreset_rd_ok", 32'(ok), 32'd1);
    chk("midreset_rd_data", d, 32'h00000042);

    // Table-driven frames and reads.
    for (int v = 0; v < 11; v++) begin
      en = tbl[v].en;
      if (!tbl[v].is_rd) begin
        send_frame(tbl[v].data, tbl[v].stop);
        en = 1'b1;
      end else begin
        do_read(tbl[v].word, d, lat, ok);
        chk($sformatf("vec%0d_rd_ok", v), 32'(ok), 32'd1);
        chk($sformatf("vec%0d_rd_data", v), d, tbl[v].exp_data);
        chk($sformatf("vec%0d_latency", v), 32'(lat), 32'(tbl[v].exp_lat));
      end
      chk($sformatf("vec%0d_count", v), 32'(fifo_count), 32'(tbl[v].exp_cnt));
      chk($sformatf("vec%0d_frame_err", v), 32'(frame_err), 32'(tbl[v].exp_ferr));
      chk($sformatf("vec%0d_overrun", v), 32'(overrun), 32'd0);
    end

    // Request issued on an empty FIFO waits for the byte.
    base   = vld_cnt;
    rd_req = 1'b1;
    rd_word = 1'b0;
    @(negedge clk);
    rd_req = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    chk("early_no_valid", 32'(vld_cnt - base), 32'd0);
    send_frame(8'h7A, 1'b1);
    lat = 0;
    while (vld_cnt == base && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    repeat (4) @(negedge clk);
    chk("late_valid_pulses", 32'(vld_cnt - base), 32'd1);
    chk("late_rd_data", vld_data, 32'h0000007A);
    chk("late_count", 32'(fifo_count), 32'd0);

`ifdef UART_PARITY_EN
    // Bad parity drops the byte and sets the sticky flag.
    par_flip = 1'b1;
    send_frame(8'h11, 1'b1);
    par_flip = 1'b0;
    chk("parity_err_set", 32'(parity_err), 32'd1);
    chk("parity_drop_count", 32'(fifo_count), 32'd0);
    send_frame(8'h11, 1'b1);
    chk("parity_good_count", 32'(fifo_count), 32'd1);
    do_read(1'b0, d, lat, ok);
    chk("parity_good_data", d, 32'h00000011);
`endif

    // Overrun: one byte more than the FIFO holds; pointers wrap meanwhile.
    for (int i = 0; i <= DEPTH; i++) send_frame(8'(8'hA0 + i), 1'b1);
    chk("ovr_count", 32'(fifo_count), 32'(DEPTH));
    chk("ovr_flag", 32'(overrun), 32'd1);
    for (int k = 0; k < DEPTH / 4; k++) begin
      logic [31:0] e;
      for (int j = 0; j < 4; j++) e = {e[23:0], 8'(8'hA0 + 4 * k + j)};
      do_read(1'b1, d, lat, ok);
      chk($sformatf("ovr_word%0d_ok", k), 32'(ok), 32'd1);
      chk($sformatf("ovr_word%0d_data", k), d, e);
      chk($sformatf("ovr_word%0d_latency", k), 32'(lat), 32'd5);
    end
    chk("ovr_final_count", 32'(fifo_count), 32'd0);
    chk("ovr_sticky", 32'(overrun), 32'd1);
    chk("ferr_sticky", 32'(frame_err), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
